// File: rtl/core_run_ctrl_pkg.sv
// Shared state type and tohost constants for the RV32I run controller.
package core_run_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_t;

  // riscv-tests reports pass as tohost==1 and fail as (code << 1) | 1.
  localparam logic [31:0] TOHOST_PASS         = 32'd1;
  localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;

endpackage

// File: rtl/core_run_ctrl_if.sv
// Core-side observation bus: data-memory write port plus the retire strobe.
interface core_run_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  retire;

  // The core drives the bus; the run controller only watches it.
  modport master (output mem_we, mem_addr, mem_wdata, retire);
  modport slave  (input  mem_we, mem_addr, mem_wdata, retire);

endinterface

// File: rtl/core_run_ctrl.sv
// Run controller: sequences core reset, counts cycles and retired
// instructions, and stops the run on a tohost store or a cycle timeout.
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           CNT_WIDTH    = 32,
  parameter int unsigned           RESET_CYCLES = 2,
  parameter int unsigned           MAX_CYCLES   = 20,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR  = ADDR_WIDTH'(DEFAULT_TOHOST_ADDR)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  core_run_ctrl_if.slave        i_mem,
  output logic                  o_core_rstn,
  output logic                  o_core_en,
  output logic                  o_running,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_timeout,
  output logic [DATA_WIDTH-1:0] o_fail_code,
  output logic [CNT_WIDTH-1:0]  o_cycle_count,
  output logic [CNT_WIDTH-1:0]  o_instret
);

  localparam int unsigned          HOLD_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]    HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam bit                   TIMEOUT_EN = (MAX_CYCLES != 0);
  // Only meaningful when TIMEOUT_EN; the compare is gated below.
  localparam logic [CNT_WIDTH-1:0] CYC_LAST   = CNT_WIDTH'(MAX_CYCLES - 1);

  run_state_t            r_state;
  logic [HOLD_W-1:0]     r_hold_cnt;
  logic                  r_core_rstn;
  logic                  r_core_en;
  logic                  r_pass;
  logic                  r_timeout;
  logic [DATA_WIDTH-1:0] r_fail_code;
  logic [CNT_WIDTH-1:0]  r_cycle_count;
  logic [CNT_WIDTH-1:0]  r_instret;

  logic w_hit;
  logic w_hit_pass;
  logic w_timeout;

  // Stores to tohost with bit 0 clear are ordinary data and do not end the run.
  assign w_hit      = i_mem.mem_we && (i_mem.mem_addr == TOHOST_ADDR) && i_mem.mem_wdata[0];
  assign w_hit_pass = (i_mem.mem_wdata == DATA_WIDTH'(TOHOST_PASS));
  // Fires on the last allowed cycle so the count freezes exactly at MAX_CYCLES.
  assign w_timeout  = TIMEOUT_EN && (r_cycle_count == CYC_LAST);

  // Run FSM with all result registers; reset and restart clear everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= HOLD;
      r_hold_cnt    <= '0;
      r_core_rstn   <= 1'b0;
      r_core_en     <= 1'b0;
      r_pass        <= 1'b0;
      r_timeout     <= 1'b0;
      r_fail_code   <= '0;
      r_cycle_count <= '0;
      r_instret     <= '0;
    end else begin
      case (r_state)
        HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state     <= RUN;
            r_core_rstn <= 1'b1;
            r_core_en   <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        RUN: begin
          // The cycle that ends the run is still counted.
          r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
          if (i_mem.retire) begin
            r_instret <= r_instret + CNT_WIDTH'(1);
          end
          if (w_hit) begin
            r_state   <= DONE;
            r_core_en <= 1'b0;
            if (w_hit_pass) begin
              r_pass <= 1'b1;
            end else begin
              r_fail_code <= i_mem.mem_wdata >> 1;
            end
          end else if (w_timeout) begin
            r_state   <= DONE;
            r_core_en <= 1'b0;
            r_timeout <= 1'b1;
          end
        end
        DONE: begin
          if (i_start) begin
            r_state       <= HOLD;
            r_hold_cnt    <= '0;
            r_core_rstn   <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_fail_code   <= '0;
            r_cycle_count <= '0;
            r_instret     <= '0;
          end
        end
        default: begin
          r_state <= HOLD;
        end
      endcase
    end
  end

  assign o_core_rstn   = r_core_rstn;
  assign o_core_en     = r_core_en;
  assign o_running     = (r_state == RUN);
  assign o_done        = (r_state == DONE);
  assign o_pass        = r_pass;
  assign o_timeout     = r_timeout;
  assign o_fail_code   = r_fail_code;
  assign o_cycle_count = r_cycle_count;
  assign o_instret     = r_instret;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: a timeout build (MAX_CYCLES=20) and a free-running
// build (MAX_CYCLES=0) share one stimulus stream and are both tracked by a
// cycle-level reference model.
module tb_core_run_ctrl;

  localparam int unsigned RST_CYC = 2;
  localparam logic [31:0] TOHOST  = 32'h0000_1000;
  localparam int          NV      = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, we = 1'b0, retire = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  int          checks = 0;
  int          errors = 0;

  core_run_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus20 ();
  core_run_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();

  assign bus20.mem_we    = we;
  assign bus20.mem_addr  = addr;
  assign bus20.mem_wdata = wdata;
  assign bus20.retire    = retire;
  assign bus0.mem_we     = we;
  assign bus0.mem_addr   = addr;
  assign bus0.mem_wdata  = wdata;
  assign bus0.retire     = retire;

  logic        a_rstn, a_en, a_run, a_done, a_pass, a_tmo;
  logic [31:0] a_fail, a_cyc, a_ret;
  logic        b_rstn, b_en, b_run, b_done, b_pass, b_tmo;
  logic [31:0] b_fail, b_cyc, b_ret;

  core_run_ctrl #(.CNT_WIDTH(32), .RESET_CYCLES(RST_CYC), .MAX_CYCLES(20)) u_dut20 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mem(bus20.slave),
    .o_core_rstn(a_rstn), .o_core_en(a_en), .o_running(a_run), .o_done(a_done),
    .o_pass(a_pass), .o_timeout(a_tmo), .o_fail_code(a_fail),
    .o_cycle_count(a_cyc), .o_instret(a_ret)
  );

  core_run_ctrl #(.CNT_WIDTH(32), .RESET_CYCLES(RST_CYC), .MAX_CYCLES(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mem(bus0.slave),
    .o_core_rstn(b_rstn), .o_core_en(b_en), .o_running(b_run), .o_done(b_done),
    .o_pass(b_pass), .o_timeout(b_tmo), .o_fail_code(b_fail),
    .o_cycle_count(b_cyc), .o_instret(b_ret)
  );

  typedef struct {
    logic rstn, en, run, done, pass, tmo;
    logic [31:0] fail, cyc, ret;
  } obs_t;

  obs_t obs20, obs0;

  always_comb begin
    obs20 = '{a_rstn, a_en, a_run, a_done, a_pass, a_tmo, a_fail, a_cyc, a_ret};
    obs0  = '{b_rstn, b_en, b_run, b_done, b_pass, b_tmo, b_fail, b_cyc, b_ret};
  end

  // Reference model: phase 0 = core held in reset, 1 = running, 2 = finished.
  typedef struct {
    int unsigned phase;
    int unsigned held;
    logic [31:0] cyc, ret, fail;
    bit          pass, tmo;
  } model_t;

  model_t m20, m0;

  function automatic model_t fresh();
    model_t m;
    m.phase = 0; m.held = 0; m.cyc = '0; m.ret = '0; m.fail = '0;
    m.pass = 1'b0; m.tmo = 1'b0;
    return m;
  endfunction

  // One clock edge of the run-controller rules, using the current bench inputs.
  function automatic model_t mstep(model_t m, int unsigned maxc);
    model_t n;
    bit     hit;
    n   = m;
    hit = we && (addr == TOHOST) && wdata[0];
    if (rst) return fresh();
    case (m.phase)
      0: begin
        n.held = m.held + 1;
        if (n.held >= RST_CYC) n.phase = 1;
      end
      1: begin
        n.cyc = m.cyc + 32'd1;
        if (retire) n.ret = m.ret + 32'd1;
        if (hit) begin
          n.phase = 2;
          n.pass  = (wdata == 32'd1);
          n.fail  = n.pass ? 32'd0 : (wdata >> 1);
        end else if (maxc != 0 && n.cyc == maxc) begin
          n.phase = 2;
          n.tmo   = 1'b1;
        end
      end
      default: if (start) n = fresh();
    endcase
    return n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cmp_model(string tag, model_t m, obs_t o);
    chk({tag, ".rstn"},    32'(o.rstn), 32'(m.phase != 0));
    chk({tag, ".en"},      32'(o.en),   32'(m.phase == 1));
    chk({tag, ".running"}, 32'(o.run),  32'(m.phase == 1));
    chk({tag, ".done"},    32'(o.done), 32'(m.phase == 2));
    chk({tag, ".pass"},    32'(o.pass), 32'(m.pass));
    chk({tag, ".timeout"}, 32'(o.tmo),  32'(m.tmo));
    chk({tag, ".fail"},    o.fail, m.fail);
    chk({tag, ".cycles"},  o.cyc,  m.cyc);
    chk({tag, ".instret"}, o.ret,  m.ret);
  endtask

  task automatic drive(bit r, bit s, bit w, logic [31:0] a, logic [31:0] d, bit rt);
    rst = r; start = s; we = w; addr = a; wdata = d; retire = rt;
  endtask

  // Inputs change on the falling edge; the model steps on the rising edge and
  // both DUTs are compared on the following falling edge.
  task automatic tick();
    @(posedge clk);
    m20 = mstep(m20, 20);
    m0  = mstep(m0, 0);
    @(negedge clk);
    cmp_model("m20", m20, obs20);
    cmp_model("m0", m0, obs0);
  endtask

  task automatic chk20(string tag, bit rstn, bit run, bit done, bit pass, bit tmo,
                       logic [31:0] fail, logic [31:0] cyc, logic [31:0] ret);
    chk({tag, ".rstn"},    32'(a_rstn), 32'(rstn));
    chk({tag, ".en"},      32'(a_en),   32'(run));
    chk({tag, ".running"}, 32'(a_run),  32'(run));
    chk({tag, ".done"},    32'(a_done), 32'(done));
    chk({tag, ".pass"},    32'(a_pass), 32'(pass));
    chk({tag, ".timeout"}, 32'(a_tmo),  32'(tmo));
    chk({tag, ".fail"},    a_fail, fail);
    chk({tag, ".cycles"},  a_cyc,  cyc);
    chk({tag, ".instret"}, a_ret,  ret);
    $display("%s: rstn=%0b run=%0b done=%0b pass=%0b tmo=%0b fail=%0h cyc=%0d ret=%0d",
             tag, a_rstn, a_run, a_done, a_pass, a_tmo, a_fail, a_cyc, a_ret);
  endtask

  // Reset pulse followed by the hold cycles; leaves both DUTs at run cycle 0.
  task automatic start_fresh_run();
    drive(1, 0, 0, '0, '0, 0); tick();
    drive(0, 0, 0, '0, '0, 0);
    for (int k = 0; k < int'(RST_CYC); k++) tick();
  endtask

  typedef struct {
    bit          rst, start, we;
    logic [31:0] addr, wdata;
    bit          retire;
    bit          e_rstn, e_run, e_done, e_pass, e_tmo;
    logic [31:0] e_fail, e_cyc, e_ret;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mkv(bit r, bit s, bit w, logic [31:0] a, logic [31:0] d, bit rt,
                               bit ern, bit erun, bit edone, bit epass, bit etmo,
                               logic [31:0] efail, logic [31:0] ecyc, logic [31:0] eret);
    vec_t v;
    v = '{r, s, w, a, d, rt, ern, erun, edone, epass, etmo, efail, ecyc, eret};
    return v;
  endfunction

  initial begin
    bit prev_done;
    m20 = fresh();
    m0  = fresh();

    // Reset, two hold cycles, a pass at run cycle 7, restart, a fail.
    vecs[0]  = mkv(1, 0, 0, 0,           0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mkv(0, 0, 0, 0,           0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mkv(0, 0, 0, 0,           0, 1,  1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 3; i <= 9; i++)
      vecs[i] = mkv(0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0, 32'(i - 2), 32'(i - 2));
    vecs[10] = mkv(0, 0, 1, TOHOST,      1, 1,  1, 0, 1, 1, 0, 0, 8, 8);
    vecs[11] = mkv(0, 0, 0, 0,           0, 1,  1, 0, 1, 1, 0, 0, 8, 8);
    vecs[12] = mkv(0, 1, 0, 0,           0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[13] = mkv(0, 0, 0, 0,           0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[14] = mkv(0, 0, 0, 0,           0, 0,  1, 1, 0, 0, 0, 0, 0, 0);
    vecs[15] = mkv(0, 1, 1, TOHOST,      6, 1,  1, 1, 0, 0, 0, 0, 1, 1);
    vecs[16] = mkv(0, 0, 1, TOHOST + 4,  1, 0,  1, 1, 0, 0, 0, 0, 2, 1);
    vecs[17] = mkv(0, 0, 1, TOHOST,      7, 0,  1, 0, 1, 0, 0, 3, 3, 1);
    vecs[18] = mkv(0, 0, 1, TOHOST,      1, 1,  1, 0, 1, 0, 0, 3, 3, 1);

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].retire);
      tick();
      chk20($sformatf("vec%0d", i), vecs[i].e_rstn, vecs[i].e_run, vecs[i].e_done,
            vecs[i].e_pass, vecs[i].e_tmo, vecs[i].e_fail, vecs[i].e_cyc, vecs[i].e_ret);
    end

    // Timeout after 20 idle cycles; the MAX_CYCLES=0 build keeps counting.
    start_fresh_run();
    for (int k = 0; k < 19; k++) tick();
    chk20("tmo_pre", 1, 1, 0, 0, 0, 0, 19, 0);
    tick();
    chk20("tmo_hit", 1, 0, 1, 0, 1, 0, 20, 0);
    drive(0, 0, 0, '0, '0, 1);
    for (int k = 0; k < 3; k++) tick();
    chk20("tmo_frozen", 1, 0, 1, 0, 1, 0, 20, 0);
    chk("nomax.running", 32'(b_run), 32'd1);
    chk("nomax.cycles", b_cyc, 32'd23);
    chk("nomax.instret", b_ret, 32'd3);
    $display("nomax: run=%0b cyc=%0d ret=%0d", b_run, b_cyc, b_ret);

    // Pass on the last allowed cycle beats the timeout.
    start_fresh_run();
    for (int k = 0; k < 19; k++) tick();
    drive(0, 0, 1, TOHOST, 32'd1, 0);
    tick();
    chk20("hit_at_19", 1, 0, 1, 1, 0, 0, 20, 0);

    // Reset in the middle of a run.
    start_fresh_run();
    drive(0, 0, 0, '0, '0, 1);
    for (int k = 0; k < 5; k++) tick();
    chk20("mid_pre", 1, 1, 0, 0, 0, 0, 5, 5);
    drive(1, 0, 0, '0, '0, 1);
    tick();
    chk20("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, '0, '0, 1);
    tick();
    chk20("mid_hold", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk20("mid_rerun", 1, 1, 0, 0, 0, 0, 0, 0);

    // Random traffic against the model; one line per run that ends.
    prev_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] a, d;
      a = ($urandom_range(0, 1) == 1) ? TOHOST : TOHOST + 32'($urandom_range(1, 8)) * 32'd4;
      d = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 15));
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) == 0, a, d, $urandom_range(0, 1) == 1);
      tick();
      if (a_done && !prev_done)
        $display("rand c=%0d: run ended pass=%0b tmo=%0b fail=%0h cyc=%0d ret=%0d",
                 c, a_pass, a_tmo, a_fail, a_cyc, a_ret);
      prev_done = a_done;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
